// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out word transmitter: one WIDTH-bit word per handshake,
// one bit per clock, with frame strobes; back-to-back words leave no gap.
//
// state | meaning
// IDLE  | nothing in flight, ready for a word
// SHIFT | bits in flight, cnt = index of the bit currently on sout
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shift;
    logic [CW-1:0]    cnt;
    logic             at_last;
    logic             accept;

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    assign at_last   = (state == SHIFT) && (cnt == LAST);
    assign din_ready = reset && ((state == IDLE) || at_last);
    assign accept    = din_valid && din_ready;
    assign busy      = sout_valid;

    // The register always holds the current bit at the output end.
    always_comb begin
        sreg_shift = '0;
        if (MSB_FIRST)
            sreg_shift = {sreg[WIDTH-2:0], 1'b0};
        else
            sreg_shift = {1'b0, sreg[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sreg        <= '0;
            cnt         <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else if (accept) begin
            state       <= SHIFT;
            sreg        <= din;
            cnt         <= '0;
            sout        <= out_bit(din);
            sout_valid  <= 1'b1;
            frame_start <= 1'b1;
            frame_end   <= 1'b0;
        end else if (state == SHIFT && !at_last) begin
            sreg        <= sreg_shift;
            cnt         <= cnt + CW'(1);
            sout        <= out_bit(sreg_shift);
            frame_start <= 1'b0;
            frame_end   <= ((cnt + CW'(1)) == LAST);
        end else if (at_last) begin
            state       <= IDLE;
            sreg        <= '0;
            cnt         <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: a bit-queue model checked every cycle for an
// MSB-first and an LSB-first instance, plus literal per-scenario expectations.
module tb_piso_shift_tx;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       dv_m  = 1'b0;
    logic       dv_l  = 1'b0;
    logic [7:0] din_m = '0;
    logic [7:0] din_l = '0;
    logic       rdy_m, so_m, sv_m, fs_m, fe_m, bz_m;
    logic       rdy_l, so_l, sv_l, fs_l, fe_l, bz_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .reset(reset), .din_valid(dv_m), .din(din_m),
        .din_ready(rdy_m), .sout(so_m), .sout_valid(sv_m),
        .frame_start(fs_m), .frame_end(fe_m), .busy(bz_m)
    );

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .din_valid(dv_l), .din(din_l),
        .din_ready(rdy_l), .sout(so_l), .sout_valid(sv_l),
        .frame_start(fs_l), .frame_end(fe_l), .busy(bz_l)
    );

    // Model: a word becomes a queue of {bit, first, last} entries in transmit
    // order; one entry is presented per clock, and a new word is taken only
    // when nothing remains queued behind the bit being shown.
    logic [2:0] q_m[$];
    logic [2:0] q_l[$];
    logic [3:0] cur_m = '0;
    logic [3:0] cur_l = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_m.delete();
            cur_m = '0;
        end else begin
            if (dv_m && q_m.size() == 0)
                for (int k = 0; k < 8; k++) q_m.push_back({din_m[7-k], k == 0, k == 7});
            if (q_m.size() > 0) cur_m = {1'b1, q_m.pop_front()};
            else                cur_m = '0;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_l.delete();
            cur_l = '0;
        end else begin
            if (dv_l && q_l.size() == 0)
                for (int k = 0; k < 8; k++) q_l.push_back({din_l[k], k == 0, k == 7});
            if (q_l.size() > 0) cur_l = {1'b1, q_l.pop_front()};
            else                cur_l = '0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Output vector order: {sout, sout_valid, frame_start, frame_end, busy, din_ready}
    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("model_msb", {26'd0, so_m, sv_m, fs_m, fe_m, bz_m, rdy_m},
                {26'd0, cur_m[2], cur_m[3], cur_m[1], cur_m[0], cur_m[3],
                 reset && (q_m.size() == 0)});
            chk("model_lsb", {26'd0, so_l, sv_l, fs_l, fe_l, bz_l, rdy_l},
                {26'd0, cur_l[2], cur_l[3], cur_l[1], cur_l[0], cur_l[3],
                 reset && (q_l.size() == 0)});
        end
    end

    task automatic xmit(input bit lsb, input logic [7:0] w, output logic [7:0] ord,
                        output logic [7:0] fsp, output logic [7:0] fep);
        @(negedge clk);
        if (lsb) begin dv_l = 1'b1; din_l = w; end
        else     begin dv_m = 1'b1; din_m = w; end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin dv_l = 1'b0; dv_m = 1'b0; end
            #3;
            ord[8-k] = lsb ? so_l : so_m;
            fsp[8-k] = lsb ? fs_l : fs_m;
            fep[8-k] = lsb ? fe_l : fe_m;
        end
        @(negedge clk);
        #3;
        chk("idle_after_word", {30'd0, lsb ? sv_l : sv_m, lsb ? rdy_l : rdy_m}, 32'h1);
    endtask

    logic [7:0]  ord, fsp, fep;
    logic [15:0] b16, r16, s16, e16;

    initial begin
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        chk("reset_msb", {26'd0, so_m, sv_m, fs_m, fe_m, bz_m, rdy_m}, 32'h0);
        chk("reset_lsb", {26'd0, so_l, sv_l, fs_l, fe_l, bz_l, rdy_l}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #3;
        chk("ready_after_reset", {31'd0, rdy_m}, 32'h1);

        // single word, MSB first
        xmit(1'b0, 8'hA5, ord, fsp, fep);
        chk("single_bits", {24'd0, ord}, 32'hA5);
        chk("single_fs", {24'd0, fsp}, 32'h80);
        chk("single_fe", {24'd0, fep}, 32'h01);

        // back-to-back with din_valid held
        @(negedge clk);
        dv_m = 1'b1; din_m = 8'hA5;
        #3;
        r16[15] = rdy_m;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) din_m = 8'h3C;
            if (k == 9) dv_m = 1'b0;
            #3;
            b16[16-k] = so_m;
            s16[16-k] = fs_m;
            e16[16-k] = fe_m;
            if (k < 16) r16[15-k] = rdy_m;
        end
        chk("b2b_bits", {16'd0, b16}, 32'hA53C);
        chk("b2b_fs", {16'd0, s16}, 32'h8080);
        chk("b2b_fe", {16'd0, e16}, 32'h0101);
        chk("b2b_ready", {16'd0, r16}, 32'h8080);
        @(negedge clk);
        #3;
        chk("b2b_idle", {31'd0, sv_m}, 32'h0);

        // LSB-first ordering
        xmit(1'b1, 8'h01, ord, fsp, fep);
        chk("lsb_01_bits", {24'd0, ord}, 32'h80);
        chk("lsb_01_fs", {24'd0, fsp}, 32'h80);
        xmit(1'b1, 8'h80, ord, fsp, fep);
        chk("lsb_80_bits", {24'd0, ord}, 32'h01);
        chk("lsb_80_fe", {24'd0, fep}, 32'h01);

        // busy hold-off: 8'hFF requested during cycle 3 of an 8'h00 frame
        @(negedge clk);
        dv_m = 1'b1; din_m = 8'h00;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) dv_m = 1'b0;
            if (k == 3) begin dv_m = 1'b1; din_m = 8'hFF; end
            if (k == 9) dv_m = 1'b0;
            #3;
            b16[16-k] = so_m;
            r16[16-k] = rdy_m;
            s16[16-k] = fs_m;
        end
        chk("holdoff_bits", {16'd0, b16}, 32'h00FF);
        chk("holdoff_ready", {16'd0, r16}, 32'h0101);
        chk("holdoff_fs", {16'd0, s16}, 32'h8080);
        @(negedge clk);
        #3;
        chk("holdoff_idle", {31'd0, sv_m}, 32'h0);

        // asynchronous reset mid-frame
        @(negedge clk);
        dv_m = 1'b1; din_m = 8'h5A;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) dv_m = 1'b0;
        end
        @(posedge clk);
        #2;
        chk("pre_reset_bit4", {30'd0, so_m, sv_m}, 32'h3);
        reset = 1'b0;
        #1;
        chk("async_clear", {26'd0, so_m, sv_m, fs_m, fe_m, bz_m, rdy_m}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #3;
        chk("held_in_reset", {26'd0, so_m, sv_m, fs_m, fe_m, bz_m, rdy_m}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        #3;
        chk("release_ready", {30'd0, rdy_m, sv_m}, 32'h2);
        xmit(1'b0, 8'hC3, ord, fsp, fep);
        chk("post_reset_bits", {24'd0, ord}, 32'hC3);
        chk("post_reset_fs", {24'd0, fsp}, 32'h80);
        chk("post_reset_fe", {24'd0, fep}, 32'h01);

        // idle default
        repeat (20) begin
            @(negedge clk);
            #3;
            chk("idle_quiet", {29'd0, so_m, sv_m, bz_m}, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
